// File: rtl/keypad_pkg.sv
// Shared types and sizes for the keypad loader: FSM state encoding, digit widths, key count.
package keypad_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 3;
  localparam int NUM_KEYS   = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RUN,
    PAUSE
  } state_t;

  // Caller guarantees a single set bit; the OR-reduction keeps the logic flat.
  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] oh);
    logic [BCD_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (oh[i]) v = v | BCD_W'(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/keypad_loader_if.sv
// Button inputs and timer-facing outputs of the keypad loader, grouped for a single port.
interface keypad_loader_if;
  import keypad_pkg::*;

  logic [NUM_KEYS-1:0] keys;
  logic                start_key;
  logic                stop_key;
  logic                zero;
  logic [BCD_W-1:0]    data;
  logic                loadn;
  logic                clearn;
  logic                enable;
  logic [1:0]          digit_count;
  logic                key_err;

  modport master (
    output keys, start_key, stop_key, zero,
    input  data, loadn, clearn, enable, digit_count, key_err
  );

  modport slave (
    input  keys, start_key, stop_key, zero,
    output data, loadn, clearn, enable, digit_count, key_err
  );

endinterface

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, optional KEYPAD_DEBOUNCE_EN filter, rising-edge press pulse.
// Press appears 2 cycles after the raw edge (plus DEBOUNCE_CYCLES when filtering).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_prev_q, level_prev_d;
  logic level;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    level_prev_d = level;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_prev_q <= level_prev_d;
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);

  logic          cand_q, cand_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt counts consecutive identical samples, saturating once the level is accepted.
  always_comb begin
    cand_d   = sync2_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_FULL) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == CNT_FULL) stable_d = sync2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  assign press = level & ~level_prev_q;

endmodule

// File: rtl/keypad_loader.sv
// Keypad front end for a BCD countdown timer: loads up to 3 digits, starts/pauses/clears the timer.
// Debounce filter enabled by KEYPAD_DEBOUNCE_EN; no backpressure, presses outside IDLE/PAUSE are dropped.
module keypad_loader
  import keypad_pkg::*;
#(
  parameter int LOAD_PULSE      = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  keypad_loader_if.slave  bus
);

  localparam logic [3:0] PULSE_LAST = 4'(LOAD_PULSE - 1);
  localparam logic [1:0] DIGITS_MAX = 2'(MAX_DIGITS);

  if (LOAD_PULSE < 1 || LOAD_PULSE > 15) begin : g_bad_pulse
    $error("keypad_loader: LOAD_PULSE must be in 1..15");
  end

  logic [NUM_KEYS+1:0] raw;
  logic [NUM_KEYS+1:0] press;
  logic [NUM_KEYS-1:0] digit_press;
  logic                start_press;
  logic                stop_press;

  assign raw = {bus.stop_key, bus.start_key, bus.keys};

  for (genvar i = 0; i < NUM_KEYS + 2; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clock(clock),
      .reset(reset),
      .raw  (raw[i]),
      .press(press[i])
    );
  end

  assign digit_press = press[NUM_KEYS-1:0];
  assign start_press = press[NUM_KEYS];
  assign stop_press  = press[NUM_KEYS+1];

  state_t           state_q, state_d;
  state_t           origin_q, origin_d;
  logic [BCD_W-1:0] data_q, data_d;
  logic [3:0]       pulse_q, pulse_d;
  logic [1:0]       digits_q, digits_d;
  logic             key_err_q, key_err_d;
  logic             clearn_q, clearn_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      origin_q  <= IDLE;
      data_q    <= '0;
      pulse_q   <= '0;
      digits_q  <= '0;
      key_err_q <= 1'b0;
      clearn_q  <= 1'b0;
    end else begin
      origin_q  <= origin_d;
      data_q    <= data_d;
      pulse_q   <= pulse_d;
      digits_q  <= digits_d;
      key_err_q <= key_err_d;
      clearn_q  <= clearn_d;
    end
  end

  // Event priority inside each state: stop, then zero, then start, then digits.
  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    data_d    = data_q;
    pulse_d   = pulse_q;
    digits_d  = digits_q;
    key_err_d = 1'b0;
    clearn_d  = 1'b1;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (stop_press) begin
          clearn_d = 1'b0;
          digits_d = '0;
          state_d  = IDLE;
        end else if (start_press) begin
          if (digits_q == '0)  key_err_d = 1'b1;
          else if (!bus.zero)  state_d   = RUN;
        end else if (|digit_press) begin
          if ($countones(digit_press) > 1 || digits_q == DIGITS_MAX) begin
            key_err_d = 1'b1;
          end else begin
            origin_d = state_q;
            data_d   = onehot_to_bcd(digit_press);
            state_d  = SETUP;
          end
        end
      end
      SETUP: begin
        pulse_d = PULSE_LAST;
        state_d = STROBE;
      end
      STROBE: begin
        if (pulse_q == '0) state_d = HOLD;
        else               pulse_d = pulse_q - 4'd1;
      end
      HOLD: begin
        digits_d = digits_q + 2'd1;
        state_d  = origin_q;
      end
      RUN: begin
        if (stop_press) begin
          state_d = PAUSE;
        end else if (bus.zero) begin
          digits_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // loadn and enable decode straight from state so reset releases them asynchronously.
  always_comb begin
    bus.loadn       = (state_q != STROBE);
    bus.enable      = (state_q == RUN);
    bus.data        = data_q;
    bus.digit_count = digits_q;
    bus.key_err     = key_err_q;
    bus.clearn      = clearn_q;
  end

endmodule

// File: tb/tb_keypad_loader.sv
// Randomized keypad operations checked against a transaction-level model of the loader.
module tb_keypad_loader;
  import keypad_pkg::*;

  localparam int LP = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  keypad_loader_if bus();

  keypad_loader #(
    .LOAD_PULSE     (LP),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 = idle, 1 = running, 2 = paused; mcount = digits held by the timer.
  int mode;
  int mcount;

  // Monitor accumulators for one operation window.
  int ld_data[$];
  int ld_w[$];
  int cur_w, cur_d, err_cnt, clr_cnt, stab_bad;
  bit in_low;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.loadn === 1'b0) begin
        if (!in_low) begin
          in_low = 1'b1;
          cur_w  = 0;
          cur_d  = int'(bus.data);
        end
        cur_w++;
        if (int'(bus.data) != cur_d) stab_bad++;
      end else if (in_low) begin
        in_low = 1'b0;
        ld_data.push_back(cur_d);
        ld_w.push_back(cur_w);
      end
      if (bus.key_err === 1'b1) err_cnt++;
      if (bus.clearn  === 1'b0) clr_cnt++;
    end
  end

  task automatic clear_mon();
    ld_data.delete();
    ld_w.delete();
    err_cnt  = 0;
    clr_cnt  = 0;
    stab_bad = 0;
  endtask

  // kind: 0 digit, 1 two digits, 2 start, 3 stop, 4 zero pulse, 5 stop+start together
  task automatic do_op(input int kind, input int d1, input int d2);
    int exp_ld[$];
    int exp_err, exp_clr, n;
    exp_err = 0;
    exp_clr = 0;
    case (kind)
      0: if (mode != 1) begin
           if (mcount == MAX_DIGITS) exp_err = 1;
           else begin exp_ld.push_back(d1); mcount++; end
         end
      1: if (mode != 1) exp_err = 1;
      2: if (mode != 1) begin
           if (mcount == 0) exp_err = 1;
           else mode = 1;
         end
      3, 5: if (mode == 1) mode = 2;
            else begin exp_clr = 1; mcount = 0; mode = 0; end
      4: if (mode == 1) begin mode = 0; mcount = 0; end
      default: ;
    endcase

    @(posedge clock); #1;
    clear_mon();
    case (kind)
      0: bus.keys[d1] = 1'b1;
      1: begin bus.keys[d1] = 1'b1; bus.keys[d2] = 1'b1; end
      2: bus.start_key = 1'b1;
      3: bus.stop_key = 1'b1;
      4: bus.zero = 1'b1;
      5: begin bus.stop_key = 1'b1; bus.start_key = 1'b1; end
      default: ;
    endcase
    if (kind == 4) begin
      @(posedge clock); #1;
      bus.zero = 1'b0;
    end else begin
      repeat (6) @(posedge clock);
      #1;
      bus.keys      = '0;
      bus.start_key = 1'b0;
      bus.stop_key  = 1'b0;
    end
    repeat (22) @(posedge clock);
    #1;

    check($sformatf("k%0d nload", kind), ld_data.size(), exp_ld.size());
    n = (ld_data.size() < exp_ld.size()) ? ld_data.size() : exp_ld.size();
    for (int i = 0; i < n; i++) begin
      check("load data", ld_data[i], exp_ld[i]);
      check("load width", ld_w[i], LP);
    end
    check($sformatf("k%0d key_err", kind), err_cnt, exp_err);
    check($sformatf("k%0d clearn", kind), clr_cnt, exp_clr);
    check("data stable", stab_bad, 0);
    check("digit_count", bus.digit_count, mcount);
    check("enable", bus.enable, (mode == 1) ? 1 : 0);
  endtask

  initial begin
    int kind, d1, d2, found;
    bus.keys      = '0;
    bus.start_key = 1'b0;
    bus.stop_key  = 1'b0;
    bus.zero      = 1'b0;
    in_low        = 1'b0;
    clear_mon();

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst loadn", bus.loadn, 1);
    check("rst clearn", bus.clearn, 0);
    check("rst enable", bus.enable, 0);
    check("rst count", bus.digit_count, 0);
    check("rst key_err", bus.key_err, 0);
    check("rst data", bus.data, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("clearn held", bus.clearn, 0);
    @(posedge clock); #1;
    check("clearn release", bus.clearn, 1);

    mode   = 0;
    mcount = 0;

    // Load 1:30, overflow, clear.
    do_op(0, 1, 0); do_op(0, 3, 0); do_op(0, 0, 0);
    do_op(0, 5, 0); do_op(3, 0, 0);
    // Load 0:05, run to zero.
    do_op(0, 0, 0); do_op(0, 5, 0); do_op(2, 0, 0); do_op(4, 0, 0);
    // Start with nothing loaded, then pause and clear.
    do_op(2, 0, 0);
    do_op(0, 7, 0); do_op(2, 0, 0); do_op(3, 0, 0); do_op(3, 0, 0);
    // Two digits at once, then stop+start while running.
    do_op(1, 1, 2);
    do_op(0, 2, 0); do_op(2, 0, 0); do_op(5, 0, 0); do_op(0, 8, 0);

    for (int t = 0; t < 120; t++) begin
      kind = $urandom_range(0, 7);
      if (kind > 5) kind = 0;
      d1 = $urandom_range(0, 9);
      d2 = (d1 + 1 + $urandom_range(0, 8)) % 10;
      do_op(kind, d1, d2);
    end

    // Reset during the second low cycle of a 4-cycle strobe.
    do_op(3, 0, 0); do_op(3, 0, 0);
    @(posedge clock); #1;
    bus.keys[9] = 1'b1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.loadn === 1'b0) begin
        found = 1;
        break;
      end
    end
    check("strobe seen", found, 1);
    @(posedge clock); #1;
    check("strobe 2nd low", bus.loadn, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async loadn", bus.loadn, 1);
    check("async enable", bus.enable, 0);
    check("async clearn", bus.clearn, 0);
    check("async count", bus.digit_count, 0);
    check("async key_err", bus.key_err, 0);
    check("async data", bus.data, 0);
    bus.keys = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("post rst clearn", bus.clearn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
